// File: rtl/load_store_request_pkg.sv
// rtl/load_store_request_pkg.sv - shared FSM encoding, funct3 widths and lane-mask helpers for the load/store path
package load_store_request_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  localparam int LANE_W = 4;

  // Lane mask for an access starting at lane 0; the low two funct3 bits carry the width
  function automatic logic [LANE_W-1:0] base_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      2'b10:   base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/load_store_request_if.sv
// rtl/load_store_request_if.sv - execute-stage request and data memory bus signals
interface load_store_request_if;

  logic        requestValid;
  logic        requestLoad;
  logic        requestStore;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] storeData;
  logic        stallPipe;
  logic        loadDataValid;
  logic [31:0] loadData;
  logic        addressMisaligned;
  logic        accessFault;
  logic        memoryEnable;
  logic        memoryWriteEnable;
  logic [31:0] memoryAddress;
  logic [3:0]  memoryByteSelect;
  logic [31:0] memoryWriteData;
  logic        memoryBusy;
  logic [31:0] memoryDataRead;

  // Request unit side: it masters the data memory bus
  modport master (
    input  requestValid, requestLoad, requestStore, funct3, address, storeData,
    input  memoryBusy, memoryDataRead,
    output stallPipe, loadDataValid, loadData, addressMisaligned, accessFault,
    output memoryEnable, memoryWriteEnable, memoryAddress, memoryByteSelect, memoryWriteData
  );

  // Pipeline and memory side
  modport slave (
    output requestValid, requestLoad, requestStore, funct3, address, storeData,
    output memoryBusy, memoryDataRead,
    input  stallPipe, loadDataValid, loadData, addressMisaligned, accessFault,
    input  memoryEnable, memoryWriteEnable, memoryAddress, memoryByteSelect, memoryWriteData
  );

endinterface

// File: rtl/load_store_request_byte_lane_align.sv
// rtl/load_store_request_byte_lane_align.sv - byte-lane mask, store data replication and misalignment check
module load_store_request_byte_lane_align
  import load_store_request_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [31:0]       store_data,
  input  logic              is_load,
  input  logic              is_store,
  output logic [LANE_W-1:0] lane_mask,
  output logic [31:0]       write_data,
  output logic              misaligned
);

  logic [6:0] mask_wide;
  logic       funct3_bad;

  // Shift the base mask into position; any lane spilling past bit 3 crosses the word
  always_comb begin
    mask_wide  = {3'b000, base_mask(funct3)} << addr_lo;
    lane_mask  = mask_wide[3:0];
    funct3_bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (is_store && funct3[2]);
    misaligned = (is_load ^ is_store) && ((|mask_wide[6:4]) || funct3_bad);
    case (funct3[1:0])
      2'b00:   write_data = {4{store_data[7:0]}};
      2'b01:   write_data = {2{store_data[15:0]}};
      default: write_data = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_request.sv
// rtl/load_store_request.sv - single-outstanding load/store request FSM on the data memory bus
module load_store_request
  import load_store_request_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                   clk,
  input logic                   rst,
  load_store_request_if.master  bus
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [29:0]         addr_q, addr_d;
  logic [LANE_W-1:0]   mask_q, mask_d;
  logic                write_q, write_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [7:0]          wait_q, wait_d;
  logic                fault_q, fault_d;
  logic [31:0]         load_data_q, load_data_d;

  logic [LANE_W-1:0]   align_mask;
  logic [31:0]         align_data;
  logic                align_misaligned;
  logic                in_idle;
  logic                accept_ok;
  logic                reject;

  load_store_request_byte_lane_align u_byte_lane_align (
    .funct3     (bus.funct3),
    .addr_lo    (bus.address[1:0]),
    .store_data (bus.storeData),
    .is_load    (bus.requestValid & bus.requestLoad),
    .is_store   (bus.requestValid & bus.requestStore),
    .lane_mask  (align_mask),
    .write_data (align_data),
    .misaligned (align_misaligned)
  );

  // Classify the presented request; only IDLE looks at the request inputs
  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    accept_ok = in_idle && bus.requestValid && (bus.requestLoad ^ bus.requestStore) &&
                !align_misaligned;
    reject    = in_idle && align_misaligned;
  end

  // State and access registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      mask_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      wait_q      <= '0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
    end
  end

  // Next state: completion wins over timeout when busy drops on the limit cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept_ok) state_d = ST_ACCESS;
      ST_ACCESS:  if (!bus.memoryBusy || (wait_q == TIMEOUT_LIMIT)) state_d = ST_RESPOND;
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Access datapath: latch the request on accept, count busy cycles, capture read data
  always_comb begin
    addr_d      = addr_q;
    mask_d      = mask_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    fault_d     = fault_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_ok) begin
          addr_d  = bus.address[31:2];
          mask_d  = align_mask;
          write_d = bus.requestStore;
          wdata_d = align_data;
          wait_d  = '0;
          fault_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (!bus.memoryBusy) begin
          if (!write_q) load_data_d = bus.memoryDataRead;
        end else if (wait_q == TIMEOUT_LIMIT) begin
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs: bus driven only in ACCESS, everything held low while reset is asserted
  always_comb begin
    bus.stallPipe         = 1'b0;
    bus.loadDataValid     = 1'b0;
    bus.loadData          = '0;
    bus.addressMisaligned = 1'b0;
    bus.accessFault       = 1'b0;
    bus.memoryEnable      = 1'b0;
    bus.memoryWriteEnable = 1'b0;
    bus.memoryAddress     = '0;
    bus.memoryByteSelect  = '0;
    bus.memoryWriteData   = '0;
    if (rst) begin
      bus.stallPipe         = accept_ok || (state_q == ST_ACCESS);
      bus.addressMisaligned = reject;
      bus.loadData          = load_data_q;
      bus.loadDataValid     = (state_q == ST_RESPOND) && !fault_q && !write_q;
      bus.accessFault       = (state_q == ST_RESPOND) && fault_q;
      if (state_q == ST_ACCESS) begin
        bus.memoryEnable      = 1'b1;
        bus.memoryWriteEnable = write_q;
        bus.memoryAddress     = {addr_q, 2'b00};
        bus.memoryByteSelect  = mask_q;
        bus.memoryWriteData   = wdata_q;
      end
    end
  end

endmodule

// File: doc/load_store_request.md
# load_store_request

Memory request side of the core's load/store path. Accepts a load or store from the execute stage, computes the byte-lane mask and lane-replicated store data, and drives a single-outstanding request/busy handshake on the data memory bus. It stalls the pipe while the access is in flight. It returns the raw 32-bit read word for the writeback stage, which performs byte extraction and sign extension. It also reports misalignment and bus timeout.

## Interface
- TIMEOUT_CYCLES, 255: maximum busy cycles before an access is aborted; range 1–255.
- clk  in  1  core clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- requestValid  in  1  execute stage presents a memory instruction
- requestLoad  in  1  instruction is a load
- requestStore  in  1  instruction is a store
- funct3  in  3  RISC-V width field: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
- address  in  32  byte address (ALU result)
- storeData  in  32  rs2 value, right-aligned
- stallPipe  out  1  holds the pipe while the request is not finished
- loadDataValid  out  1  one-cycle pulse; loadData is valid
- loadData  out  32  raw word-aligned read data
- addressMisaligned  out  1  one-cycle pulse; request rejected
- accessFault  out  1  one-cycle pulse; bus timeout
- memoryEnable  out  1  bus request
- memoryWriteEnable  out  1  request is a write
- memoryAddress  out  32  {address[31:2], 2'b00}
- memoryByteSelect  out  4  active byte lanes
- memoryWriteData  out  32  lane-replicated store data
- memoryBusy  in  1  slave not finished
- memoryDataRead  in  32  read data, valid in the completing cycle

## Operation
- States: IDLE, ACCESS, RESPOND. Reset state is IDLE.
- **IDLE accept:** a request is accepted when requestValid=1 and exactly one of requestLoad/requestStore is 1.
  - A request with both flags or neither flag set is ignored: no bus activity and no pulse.
- **Base mask:** word 1111, half 0011, byte 0001. The 7-bit value {3'b0, base} << address[1:0] gives the lane mask.
- **Rejection:** the request is rejected if lane-mask bits [6:4] are nonzero or funct3 is invalid for the operation.
  - Invalid funct3 values: 011, 110, 111; for stores, additionally 100 and 101.
  - A rejected request sets addressMisaligned=1 in that same IDLE cycle (combinational pulse), stays in IDLE, and leaves memoryEnable=0.
  - The requester drops requestValid on the next pipe step.
- **Valid request:** the address, lane mask, write flag and store data are registered, and the FSM moves to ACCESS.
- **Store data replication:** byte → {4{storeData[7:0]}}; half → {2{storeData[15:0]}}; word → unchanged.
- **ACCESS:**
  - memoryEnable=1; the bus outputs are held stable from registers.
  - The access completes on the first cycle with memoryBusy=0. On completion, memoryDataRead is captured into loadData (loads only) and the FSM moves to RESPOND.
  - Each cycle with memoryBusy=1 increments an 8-bit wait counter. When the counter equals TIMEOUT_CYCLES, the FSM aborts to RESPOND with a fault flag set.
- **RESPOND:** lasts one cycle.
  - For a completed load, loadDataValid=1. For a completed store, no valid pulse.
  - For a timeout, accessFault=1 and loadData is unchanged.
  - The FSM then returns to IDLE unconditionally. Request inputs are ignored in RESPOND because they still belong to the finished instruction.
- **Stall:** stallPipe = (IDLE and a valid request is accepted, not rejected) or ACCESS. stallPipe is 0 in RESPOND, so the pipe steps at the end of RESPOND.
- **Reset:** asserting rst in any state asynchronously forces IDLE and drives all outputs to 0.
  - This includes memoryEnable dropping mid-access and loadData=0.
  - A bus cycle abandoned by reset is not retried.

## Timing
- Zero-wait load:
  - Cycle 0 (IDLE): accept, stallPipe=1.
  - Cycle 1 (ACCESS): memoryEnable=1, memoryBusy=0.
  - Cycle 2 (RESPOND): loadDataValid=1, stallPipe=0.
- Each busy cycle adds one cycle to the latency.
- The minimum issue interval is 3 cycles. Only one request is outstanding at a time.
- Timeout: accessFault is asserted on cycle TIMEOUT_CYCLES+2 after accept when memoryBusy stays high.
- memoryEnable never toggles within an access, and bus outputs never change while memoryEnable=1.

## Structure
- **Shared package:** FSM state encoding, funct3 width constants (BYTE/HALF/WORD, unsigned variants) and the 4-bit lane-mask width. The package is also consumed by the writeback stage.
- **Sub-module:** byte_lane_align, combinational. Inputs: funct3, address[1:0], storeData, isLoad/isStore. Outputs: lane mask, replicated data, misaligned flag. The FSM and counter stay in the top module.

## Test plan
- SW, address 0x100, storeData 0xDEADBEEF, memoryBusy=0 → memoryAddress 0x100, byteSelect 1111, writeData 0xDEADBEEF, memoryWriteEnable=1, stallPipe high for 2 cycles, no loadDataValid.
- LB, address 0x203, 2 busy cycles, memoryDataRead 0x80112233 → byteSelect 1000, memoryAddress 0x200, loadDataValid on cycle 4 with loadData 0x80112233.
- SH, address 0x3, storeData 0x0000ABCD → addressMisaligned pulse in cycle 0, memoryEnable stays 0, stallPipe 0; SH at 0x2 → byteSelect 1100, writeData 0xABCDABCD.
- LW with memoryBusy held high, TIMEOUT_CYCLES=4 → accessFault pulse on cycle 6, no loadDataValid, FSM back in IDLE on cycle 7.
- rst asserted in the second ACCESS cycle of a busy load → memoryEnable and stallPipe drop asynchronously, all outputs 0; a new LW after release completes normally.
- Two back-to-back zero-wait loads (requestValid changes on the pipe step) → exactly two loadDataValid pulses, 3 cycles apart; request held during RESPOND is not reissued.
